transmit_parity_fifo: RTL and testbench

//   Transmit side of the 10-bit parity link. Buffers 9-bit payloads from a

---
 rtl/transmit_parity_fifo.sv | 81 ++++++++
 tb/tb_transmit_parity_fifo.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/transmit_parity_fifo.sv
// transmit_parity_fifo: FIFO-buffered 9-bit payload transmitter emitting {even-parity, payload} words with programmable pacing
//   clk, reset        : single clock, synchronous active-high reset
//   in_data/in_corrupt: payload and force-bad-parity flag, stored together
//   in_valid/in_ready : source handshake; in_ready uses the registered count only
//   data_out/tx_valid : registered word and its 1-cycle strobe
//   fifo_count        : entries currently held
//   overflow          : sticky, set when a word is offered while not ready
module transmit_parity_fifo #(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8:0]               in_data,
    input  logic                     in_corrupt,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [9:0]               data_out,
    output logic                     tx_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GI = (GAP > 0) ? GAP - 1 : 0;
    typedef enum logic {S_IDLE, S_GAP} state_t;
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_q;
    state_t        state_q;
    logic [9:0]    data_q, head;
    logic          tx_q, ovf_q, push, pop;
    assign in_ready   = ~reset & (count_q < CW'(DEPTH));
    assign push       = in_valid & in_ready;
    assign pop        = (state_q == S_IDLE) & (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign data_out   = data_q;
    assign tx_valid   = tx_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_corrupt, in_data};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            state_q  <= S_IDLE;
            data_q   <= '0;
            tx_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_q | (in_valid & ~in_ready);
            tx_q     <= pop;
            // stored bit 9 is the corrupt flag; it flips the even-parity bit
            if (pop) data_q <= {(^head[8:0]) ^ head[9], head[8:0]};
            if (state_q == S_IDLE) begin
                if (pop && GAP > 0) begin
                    state_q <= S_GAP;
                    gap_q   <= GW'(GI);
                end
            end else if (gap_q == '0) begin
                state_q <= S_IDLE;
            end else begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_transmit_parity_fifo.sv
// tb_transmit_parity_fifo: directed checks of transmit_parity_fifo with GAP=0 and GAP=2 instances
module tb_transmit_parity_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] da, db;
    logic       ca, cb, va, vb;
    logic       ra, rb, tva, tvb, ova, ovb;
    logic [9:0] doa, dob;
    logic [2:0] cnta, cntb;
    int         nchk = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    transmit_parity_fifo #(.DEPTH(4), .GAP(0)) u_a (
        .clk(clk), .reset(reset), .in_data(da), .in_corrupt(ca), .in_valid(va),
        .in_ready(ra), .data_out(doa), .tx_valid(tva), .fifo_count(cnta), .overflow(ova));

    transmit_parity_fifo #(.DEPTH(4), .GAP(2)) u_b (
        .clk(clk), .reset(reset), .in_data(db), .in_corrupt(cb), .in_valid(vb),
        .in_ready(rb), .data_out(dob), .tx_valid(tvb), .fifo_count(cntb), .overflow(ovb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] enc(input logic [8:0] p, input logic c);
        return {(^p) ^ c, p};
    endfunction

    initial begin
        reset = 1'b1; va = 0; vb = 0; da = 0; db = 0; ca = 0; cb = 0;
        tick(); tick();
        reset = 1'b0;
        // 1: random traffic, then reset for 2 cycles
        for (int i = 0; i < 8; i++) begin
            va = 1; vb = 1;
            da = 9'($urandom); db = 9'($urandom);
            ca = 1'($urandom); cb = 1'($urandom);
            tick();
        end
        reset = 1'b1;
        #1;
        chk("rdy_a_in_reset", ra, 0);
        chk("rdy_b_in_reset", rb, 0);
        tick(); tick();
        chk("rst_dout_a", doa, 10'h000);
        chk("rst_tv_a", tva, 0);
        chk("rst_cnt_a", cnta, 0);
        chk("rst_ovf_a", ova, 0);
        chk("rst_dout_b", dob, 10'h000);
        chk("rst_tv_b", tvb, 0);
        chk("rst_cnt_b", cntb, 0);
        chk("rst_ovf_b", ovb, 0);
        reset = 1'b0; va = 0; vb = 0; ca = 0; cb = 0;
        #1;
        chk("rdy_a_after", ra, 1);
        chk("rdy_b_after", rb, 1);
        tick();
        // 2: single word 1A5 on GAP=0
        da = 9'h1A5; ca = 0; va = 1;
        tick();
        va = 0;
        chk("t2_cnt_push", cnta, 1);
        chk("t2_tv_push", tva, 0);
        tick();
        chk("t2_dout", doa, 10'h3A5);
        chk("t2_tv", tva, 1);
        chk("t2_rx_valid", ~^doa, 1);
        chk("t2_cnt_pop", cnta, 0);
        tick();
        chk("t2_tv_off", tva, 0);
        chk("t2_dout_hold", doa, 10'h3A5);
        // 3: 003 then 0FF with corrupt
        da = 9'h003; ca = 0; va = 1;
        tick();
        da = 9'h0FF; ca = 1;
        tick();
        va = 0; ca = 0;
        chk("t3_dout1", doa, 10'h003);
        chk("t3_tv1", tva, 1);
        chk("t3_rx1", ~^doa, 1);
        chk("t3_cnt1", cnta, 1);
        tick();
        chk("t3_dout2", doa, 10'h2FF);
        chk("t3_tv2", tva, 1);
        chk("t3_rx2", ~^doa, 0);
        chk("t3_cnt2", cnta, 0);
        tick();
        chk("t3_tv_off", tva, 0);
        // 6a: stream 10 words through GAP=0, pointers wrap
        for (int i = 0; i < 10; i++) begin
            da = 9'(9'h40 + i); ca = 1'(i % 3 == 0); va = 1;
            tick();
            if (i > 0) begin
                chk("t6_tv", tva, 1);
                chk("t6_word", doa, enc(9'(9'h40 + i - 1), 1'((i - 1) % 3 == 0)));
            end
        end
        va = 0; ca = 0;
        tick();
        chk("t6_tv_last", tva, 1);
        chk("t6_word_last", doa, enc(9'h49, 1'b1));
        chk("t6_ovf_a", ova, 0);
        tick();
        chk("t6_tv_end", tva, 0);
        // 4 + 5: GAP=2 fill to 4, forced push while full, drain in order
        for (int e = 1; e <= 20; e++) begin
            vb = (e <= 7);
            db = (e == 7) ? 9'h1EE : 9'(e);
            cb = 0;
            if (e <= 6) chk("t4_ready", rb, 1);
            if (e == 7) chk("t5_ready_full", rb, 0);
            tick();
            vb = 0;
            chk("t4_tv", tvb, 32'((e % 3 == 2) && (e <= 17)));
            if ((e % 3 == 2) && (e <= 17)) chk("t4_word", dob, enc(9'((e + 1) / 3), 1'b0));
            if (e == 6) begin
                chk("t4_cnt_full", cntb, 4);
                chk("t4_ready_low", rb, 0);
                chk("t4_ovf_clean", ovb, 0);
            end
            if (e == 7) begin
                chk("t5_ovf_set", ovb, 1);
                chk("t5_cnt_stay", cntb, 4);
            end
        end
        chk("t5_ovf_held", ovb, 1);
        chk("t5_cnt_empty", cntb, 0);
        // 6b: reset with 3 words queued
        for (int e = 1; e <= 4; e++) begin
            vb = 1; db = 9'(9'h50 + e);
            tick();
        end
        vb = 0;
        chk("t6_cnt_queued", cntb, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_ovf_cleared", ovb, 0);
        for (int e = 0; e < 6; e++) begin
            tick();
            chk("t6_no_tv", tvb, 0);
            chk("t6_cnt_zero", cntb, 0);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
